// File: rtl/hdb3_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdb3_tx_sched_pkg
// Description : Shared definitions for the HDB3 transmit scheduler:
//               - line symbol codes, also used by the polar stage
//               - serializer FSM state encodings
//               - pulse-parity update helper
// Revision    : 1.0 - initial release
// ============================================================================
package hdb3_tx_sched_pkg;

    // Symbol codes handed to the polar stage
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_MARK = 2'b01;
    localparam logic [1:0] CODE_B    = 2'b10;
    localparam logic [1:0] CODE_V    = 2'b11;

    // Serializer FSM encodings
    localparam int         STATE_W  = 1;
    localparam logic [STATE_W-1:0] ST_EMPTY = 1'b0;  // no bits held
    localparam logic [STATE_W-1:0] ST_SHIFT = 1'b1;  // 1..DATA_W bits held

    // Pulse parity after emitting 'code': marks and B pulses toggle it,
    // a V pulse restarts the count, a zero leaves it alone. 1 = odd.
    function automatic logic parity_after(input logic parity, input logic [1:0] code);
        logic p;
        p = parity;
        case (code)
            CODE_MARK, CODE_B: p = ~parity;
            CODE_V:            p = 1'b0;
            default:           p = parity;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdb3_subst_win.sv
`default_nettype none
// ============================================================================
// Module      : hdb3_subst_win
// Description : Four-slot HDB3 code window (w3 oldest .. w0 newest) with
//               four-zero substitution.
//               On each tick, the window shifts toward w3 and the new bit
//               enters w0. If the three post-shift slots and the entering
//               bit are all zero, the window is rewritten as 000V (odd
//               parity) or B00V (even parity).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               tick          - advance the window by one line bit
//               din_bit       - entering serial bit
//               parity        - pulse parity including the code emitted
//                               on this same tick (1 = odd)
//               emit_code     - slot w3, the code emitted on the next tick
// Revision    : 1.0 - initial release
// ============================================================================
module hdb3_subst_win
    import hdb3_tx_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       din_bit,
    input  logic       parity,
    output logic [1:0] emit_code
);

    logic [1:0] r_win [4];
    logic       w_zero_run;

    // Slots w2..w0 become w3..w1 after the shift. Substituted slots are
    // non-zero, so a finished substitution never seeds the next zero run.
    assign w_zero_run = (r_win[2] == CODE_ZERO) && (r_win[1] == CODE_ZERO) &&
                        (r_win[0] == CODE_ZERO) && !din_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win[3] <= CODE_ZERO;
            r_win[2] <= CODE_ZERO;
            r_win[1] <= CODE_ZERO;
            r_win[0] <= CODE_ZERO;
        end else if (tick) begin
            if (w_zero_run) begin
                r_win[3] <= parity ? CODE_ZERO : CODE_B;
                r_win[2] <= CODE_ZERO;
                r_win[1] <= CODE_ZERO;
                r_win[0] <= CODE_V;
            end else begin
                r_win[3] <= r_win[2];
                r_win[2] <= r_win[1];
                r_win[1] <= r_win[0];
                r_win[0] <= din_bit ? CODE_MARK : CODE_ZERO;
            end
        end
    end

    assign emit_code = r_win[3];

endmodule
`default_nettype wire

// File: rtl/hdb3_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : hdb3_tx_sched
// Description : HDB3 transmit scheduler. Serializes DATA_W-bit words MSB
//               first, one line bit per bit_tick, inserts filler zeros when
//               no word is available, and produces HDB3 symbol codes through
//               a four-slot substitution window.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               bit_tick      - one code emitted per tick
//               din/din_valid/din_ready - word input handshake
//               code          - 00 zero, 01 mark, 10 B pulse, 11 V pulse
//               underrun      - one-cycle pulse after a filler zero enters
//               viol_cnt      - count of emitted V codes (optional)
// Options     : HDB3_TX_SCHED_STATS_EN - adds the viol_cnt output/counter
// Revision    : 1.0 - initial release
// ============================================================================
module hdb3_tx_sched
    import hdb3_tx_sched_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_tick,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [1:0]        code,
    output logic              underrun
`ifdef HDB3_TX_SCHED_STATS_EN
    ,
    output logic [15:0]       viol_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [DATA_W-1:0]  r_sreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_xfer;
    logic               w_bit;
    logic               w_fill;
    logic [1:0]         w_emit;
    logic               w_par_eff;
    logic               r_parity;
    logic [1:0]         r_code;
    logic               r_underrun;

    assign w_xfer = din_valid & din_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (bit_tick && (r_cnt == CNT_W'(1)) && !w_xfer)
                          w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A transfer during the last-bit tick reloads without a gap.
    always_comb begin
        din_ready = 1'b0;
        w_bit     = 1'b0;
        w_fill    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_EMPTY: begin
                    din_ready = 1'b1;
                    w_fill    = bit_tick;
                end
                ST_SHIFT: begin
                    din_ready = bit_tick && (r_cnt == CNT_W'(1));
                    w_bit     = r_sreg[DATA_W-1];
                end
                default: ;
            endcase
        end
    end

    // ---------------- Serializer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_xfer) begin
            r_sreg <= din;
            r_cnt  <= CNT_W'(DATA_W);
        end else if (bit_tick && (r_state == ST_SHIFT)) begin
            r_sreg <= r_sreg << 1;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // ---------------- Window / substitution ----------------
    // The substitution decision sees the parity that already includes the
    // code leaving w3 on this tick.
    assign w_par_eff = parity_after(r_parity, w_emit);

    hdb3_subst_win u_win (
        .clk       (clk),
        .rst       (rst),
        .tick      (bit_tick),
        .din_bit   (w_bit),
        .parity    (w_par_eff),
        .emit_code (w_emit)
    );

    // ---------------- Code output, parity, underrun ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code     <= CODE_ZERO;
            r_parity   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_fill;
            if (bit_tick) begin
                r_code   <= w_emit;
                r_parity <= w_par_eff;
            end else begin
                r_code   <= CODE_ZERO;
            end
        end
    end

    assign code     = r_code;
    assign underrun = r_underrun;

`ifdef HDB3_TX_SCHED_STATS_EN
    logic [15:0] r_viol_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_viol_cnt <= '0;
        end else if (bit_tick && (w_emit == CODE_V)) begin
            r_viol_cnt <= r_viol_cnt + 16'd1;
        end
    end

    assign viol_cnt = r_viol_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hdb3_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdb3_tx_sched
// Description : Directed scoreboard bench for hdb3_tx_sched. The stimulus
//               process queues the hand-derived expectation for each cycle;
//               a monitor process pops it and compares din_ready (during the
//               cycle) and code/underrun (after the edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdb3_tx_sched;

    typedef struct {
        logic       ready;
        logic [1:0] code;
        logic       care;
        logic       under;
        logic       vcare;
        logic [15:0] viol;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       bit_tick;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] code;
    logic       underrun;
`ifdef HDB3_TX_SCHED_STATS_EN
    logic [15:0] viol_cnt;
`endif

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks   = 0;
    int    failures = 0;
    string cur_name = "reset";
    logic        g_vcare = 1'b0;
    logic [15:0] g_viol  = 16'd0;

    // Hand-derived code tables (index 0 = first tick)
    logic [1:0] tbl_zero [9]  = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b11,
                                  2'b10, 2'b00, 2'b00, 2'b11};
    logic [1:0] tbl_80   [16] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                                  2'b00, 2'b00, 2'b00, 2'b11, 2'b10,
                                  2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [1:0] tbl_idle [12] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10,
                                  2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00};

    hdb3_tx_sched #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_tick  (bit_tick),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .code      (code),
        .underrun  (underrun)
`ifdef HDB3_TX_SCHED_STATS_EN
        ,
        .viol_cnt  (viol_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input string what, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s/%s: got %0h want %0h at %0t", nm, what, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk(mon_e.name, "din_ready", {15'd0, din_ready}, {15'd0, mon_e.ready});
                @(posedge clk);
                #1;
                if (mon_e.care)
                    chk(mon_e.name, "code", {14'd0, code}, {14'd0, mon_e.code});
                chk(mon_e.name, "underrun", {15'd0, underrun}, {15'd0, mon_e.under});
`ifdef HDB3_TX_SCHED_STATS_EN
                if (mon_e.vcare)
                    chk(mon_e.name, "viol_cnt", viol_cnt, mon_e.viol);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle and queue what it must produce.
    task automatic step(input logic r, input logic t, input logic v, input logic [7:0] d,
                        input logic er, input logic [1:0] ec, input logic cc, input logic eu);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bit_tick  = t;
        din_valid = v;
        din       = d;
        e.ready = er;
        e.code  = ec;
        e.care  = cc;
        e.under = eu;
        e.vcare = g_vcare;
        e.viol  = g_viol;
        e.name  = cur_name;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cur_name = "reset";
`ifdef HDB3_TX_SCHED_STATS_EN
        g_vcare = 1'b1;
        g_viol  = 16'd0;
`endif
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        g_vcare = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bit_tick = 1'b0; din_valid = 1'b0; din = 8'h00;

        // 0xFF: eight marks, each bit visible 5 cycles after its tick
        do_reset();
        cur_name = "ff";
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++)
            step(1'b0, 1'b1, 1'b0, 8'h00, (i >= 8), (i <= 4) ? 2'b00 : 2'b01, 1'b1, (i >= 9));

        // 0x00: B00V pairs from even parity
        do_reset();
        cur_name = "zero";
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++)
            step(1'b0, 1'b1, 1'b0, 8'h00, (i >= 8), tbl_zero[i-1], 1'b1, (i == 9));

        // 0x80 then 0x00 back to back: 000V after odd parity, then B00V
        do_reset();
        cur_name = "x80_x00";
        step(1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++)
            step(1'b0, 1'b1, (i == 8), 8'h00, (i == 8) || (i == 16), tbl_80[i-1], 1'b1, 1'b0);

        // No data for 12 ticks: filler zeros, underrun every tick
        do_reset();
        cur_name = "idle";
        for (int i = 1; i <= 12; i++)
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, tbl_idle[i-1], 1'b1, 1'b1);

        // Reset during the 3rd bit of the second word
        do_reset();
        cur_name = "midrst";
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++)
            step(1'b0, 1'b1, (i == 8), 8'hFF, (i == 8), (i <= 4) ? 2'b00 : 2'b01, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
        cur_name = "postrst";
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++)
            step(1'b0, 1'b1, 1'b0, 8'h00, (i >= 8), tbl_zero[i-1], 1'b1, (i == 9));

`ifdef HDB3_TX_SCHED_STATS_EN
        // Three zero bytes: six V pulses once the window drains
        do_reset();
        cur_name = "stats";
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            g_vcare = (i == 24) || (i == 25);
            g_viol  = (i == 25) ? 16'd6 : 16'd5;
            step(1'b0, 1'b1, (i == 8) || (i == 16), 8'h00,
                 (i == 8) || (i == 16) || (i >= 24), 2'b00, 1'b0, (i == 25));
        end
        g_vcare = 1'b0;
`endif

        @(negedge clk);
        bit_tick = 1'b0; din_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hdb3_tx_sched.md
HDB3_TX_SCHED -- requirements
Module: hdb3_tx_sched

Interface
REQ-001 Parameter: DATA_W, default 8, width of the input data word.
REQ-002 Port: clk, input, 1, single clock; all logic is rising-edge.
REQ-003 Port: rst, input, 1, synchronous reset, active-high.
REQ-004 Port: bit_tick, input, 1, line-bit strobe; one code emitted per tick; tie high for one bit per clk.
REQ-005 Port: din, input, DATA_W, data word, serialized MSB first.
REQ-006 Port: din_valid, input, 1, din holds a word.
REQ-007 Port: din_ready, output, 1, block accepts din this cycle.
REQ-008 Port: code, output, 2, symbol code to the polar stage: 00 zero, 01 data mark, 10 B pulse, 11 V pulse.
REQ-009 Port: underrun, output, 1, one-cycle pulse when a filler zero is inserted.

Function
REQ-010 The word transfer SHALL occur on a rising edge with din_valid=1 and din_ready=1.
REQ-011 din_ready SHALL be 1 when the serializer is empty, or when it holds one bit and bit_tick=1; otherwise it is 0.
REQ-012 FSM states: EMPTY (no bits held) and SHIFT (1..DATA_W bits held).
- EMPTY->SHIFT on transfer.
- SHIFT->EMPTY on the tick consuming the last bit with no transfer in the same cycle.
- SHIFT->SHIFT reloads with no gap when a transfer coincides with the last-bit tick.
REQ-013 On each tick, the next serial bit SHALL enter window slot w0, and w3..w1 SHALL shift toward the output.
- The entering bit is the serializer MSB in SHIFT.
- In EMPTY it is a filler 0, and underrun pulses in the following cycle.
REQ-014 An entering 1 SHALL be stored as 01; an entering 0 SHALL be stored as 00.
REQ-015 On the same tick, if the post-shift slots w3..w1 are all 00 and the entering bit is 0, the window SHALL be rewritten before storage.
- Pulse parity odd: 000V (w3..w0 = 00,00,00,11).
- Pulse parity even: B00V (10,00,00,11).
REQ-016 Pulse parity SHALL toggle on each emitted 01 or 10 and clear on each emitted 11.
- The substitution decision uses the parity value that already includes the code emitted on that same tick.
REQ-017 On each tick, the old w3 SHALL be registered onto code for exactly one clk; code is 00 in all cycles without a preceding tick.
- Latency: a bit entering at tick n appears on code in the cycle after tick n+4.
REQ-018 Substituted slots are non-zero and SHALL NOT count toward a later zero run, so runs of 8 zeros yield two independent substitutions.
REQ-019 Transfers with bit_tick=0 SHALL load the serializer without emitting any code.

Reset
REQ-020 While rst=1, the following SHALL be forced: code=00, underrun=0, din_ready=0, state=EMPTY, window all 00, parity even.
REQ-021 On the first cycle after rst falls, din_ready SHALL be 1.
REQ-022 A word partially serialized when rst asserts SHALL be discarded.

Configuration
REQ-023 Macro HDB3_TX_SCHED_STATS_EN SHALL control a statistics counter.
- Defined: adds output viol_cnt[15:0], which counts emitted 11 codes, wraps at 0xFFFF->0, and is cleared by rst.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Structure
REQ-024 A shared package SHALL hold:
- code constants CODE_ZERO=00, CODE_MARK=01, CODE_B=10, CODE_V=11;
- FSM state encodings.
The polar stage uses the same code constants.
REQ-025 The 4-slot window and substitution logic SHALL be a sub-module, hdb3_subst_win (inputs: tick, bit, parity; output: emitted code).
- Serializer, FSM and parity remain in the top module.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- After reset, din=0xFF, tick every clk: code = eight 01 starting 5 cycles after the first bit tick.
- After reset, din=0x00: code = 10,00,00,11,10,00,00,11.
- din=0x80 then 0x00: code = 01,00,00,00,11 (parity odd -> 000V), then 10,00,00,11 for the following zeros.
- din_valid=0 for 12 ticks: underrun pulses 12 times, and code carries the B00V/000V pattern with no run of four 00.
- rst asserted mid-word after 3 bits: code=00 next cycle, din_ready=1 on the first cycle after release, and the next word starts from even parity.
- STATS_EN defined, 3 bytes of 0x00: viol_cnt=6.
